// File: rtl/fas_peak_analyzer.sv
// fas_peak_analyzer
//   Streaming FFT-bin peak finder. Bins arrive one per accepted cycle over a
//   valid/ready handshake. Each bin's magnitude is computed in a two-stage
//   pipeline. A running peak is tracked across a frame of NBINS bins. The peak
//   index and magnitude are then reported together with a one-cycle done pulse.
//   Optional build macro: FAS_MAG_APPROX_EN selects |re|+|im| instead of re^2+im^2.
module fas_peak_analyzer #(
    parameter int DW            = 16,
    parameter int NBINS         = 16,
    parameter int IDXW          = $clog2(NBINS),
    parameter int HALF_SPECTRUM = 1,
    parameter int SKIP_DC       = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bin_valid,
    output logic              bin_ready,
    input  logic [2*DW-1:0]   bin_d,
    input  logic              frame_start,
    output logic              done,
    output logic [IDXW-1:0]   freq,
    output logic [2*DW-1:0]   peak_mag,
    output logic              busy
);

    localparam int MW = 2 * DW;
`ifdef FAS_MAG_APPROX_EN
    // |x| of the most negative value is 2^(DW-1), so one extra bit is needed.
    localparam int AW = DW + 1;
`else
    localparam int AW = 2 * DW;
`endif

    typedef enum logic [1:0] {ACC, DRAIN1, DRAIN2} state_t;

    state_t            state;
    state_t            state_next;

    logic              accept;
    logic [IDXW-1:0]   cnt;
    logic [IDXW-1:0]   idx;
    logic              last_bin;
    logic              elig;
    logic              discard;

    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic [AW-1:0]     term_re;
    logic [AW-1:0]     term_im;

    logic              s1_valid;
    logic [AW-1:0]     s1_re;
    logic [AW-1:0]     s1_im;
    logic [IDXW-1:0]   s1_idx;
    logic              s1_elig;

    logic [AW-1:0]     mag_sum;
    logic [MW-1:0]     mag;
    logic              better;

    logic              run_valid;
    logic [MW-1:0]     run_max;
    logic [IDXW-1:0]   run_idx;

    assign accept = bin_valid && bin_ready;

    // A frame_start accept renumbers its bin to 0; otherwise the counter names it.
    assign idx      = frame_start ? '0 : cnt;
    assign last_bin = &idx;
    assign discard  = accept && frame_start && (cnt != '0);

    // Upper-half bins have the index MSB set because NBINS is a power of two.
    assign elig = !((HALF_SPECTRUM != 0) && idx[IDXW-1]) &&
                  !((SKIP_DC != 0) && (idx == '0));

    assign re = bin_d[2*DW-1:DW];
    assign im = bin_d[DW-1:0];

`ifdef FAS_MAG_APPROX_EN
    logic signed [DW:0] re_ext;
    logic signed [DW:0] im_ext;

    assign re_ext  = {re[DW-1], re};
    assign im_ext  = {im[DW-1], im};
    assign term_re = re_ext[DW] ? AW'(-re_ext) : AW'(re_ext);
    assign term_im = im_ext[DW] ? AW'(-im_ext) : AW'(im_ext);
`else
    logic signed [2*DW-1:0] re_w;
    logic signed [2*DW-1:0] im_w;
    logic signed [2*DW-1:0] sq_re;
    logic signed [2*DW-1:0] sq_im;

    // Sign-extend first so the product keeps full precision at 2*DW bits.
    assign re_w    = {{DW{re[DW-1]}}, re};
    assign im_w    = {{DW{im[DW-1]}}, im};
    assign sq_re   = re_w * re_w;
    assign sq_im   = im_w * im_w;
    assign term_re = sq_re;
    assign term_im = sq_im;
`endif

    // Each term is at most half the sum range, so the sum cannot wrap.
    assign mag_sum = s1_re + s1_im;
    assign mag     = MW'(mag_sum);
    assign better  = s1_valid && s1_elig && (!run_valid || (mag > run_max));

    // State register.
    // NOTE: clocked state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ACC;
        else      state <= state_next;
    end

    // Next-state logic: collect a frame, then two drain cycles for the pipeline.
    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        state_next = state;
        unique case (state)
            ACC:     if (accept && last_bin) state_next = DRAIN1;
            DRAIN1:  state_next = DRAIN2;
            DRAIN2:  state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    // Output decode: ready only in ACC and never while reset is held.
    always_comb begin
        bin_ready = rst && (state == ACC);
        busy      = (state != ACC) || (cnt != '0);
    end

    // Bin counter. It wraps naturally at NBINS because NBINS is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        cnt <= '0;
        else if (accept) cnt <= idx + IDXW'(1);
    end

    // S1: capture squared or absolute terms, the index and the eligibility flag.
    // NOTE: datapath registers are reset too, so no X ever reaches the compare.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_idx   <= '0;
            s1_elig  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_re   <= term_re;
                s1_im   <= term_im;
                s1_idx  <= idx;
                s1_elig <= elig;
            end
        end
    end

    // S2: running max. It is cleared after reporting and on resync, which also drops the stale bin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_valid <= 1'b0;
            run_max   <= '0;
            run_idx   <= '0;
        end else if ((state == DRAIN2) || discard) begin
            run_valid <= 1'b0;
            run_max   <= '0;
            run_idx   <= '0;
        end else if (better) begin
            run_valid <= 1'b1;
            run_max   <= mag;
            run_idx   <= s1_idx;
        end
    end

    // Result registers: load the frame peak and pulse done when leaving DRAIN2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done     <= 1'b0;
            freq     <= '0;
            peak_mag <= '0;
        end else begin
            done <= (state == DRAIN2);
            if (state == DRAIN2) begin
                freq     <= run_idx;
                peak_mag <= run_max;
            end
        end
    end

endmodule

// File: doc/fas_peak_analyzer.md
Name: fas_peak_analyzer

Overview:
- Parametrised, streaming successor of the frequency-analysis stage in the FIR -> FFT -> analysis chain.
- Accepts FFT bins serially, one complex bin per accepted cycle, over a valid/ready handshake.
- Computes each bin's magnitude, tracks the running peak over a frame of NBINS bins, and reports the peak index and magnitude with a one-cycle done pulse.
- Adds what the 16-bin fixed analyser lacks: configurable bin count and width, half-spectrum search, DC skip, frame resync and backpressure.

Parameters:
DW, 16, signed width of each real/imag component
NBINS, 16, bins per frame; power of two, 4..1024
IDXW, $clog2(NBINS), width of bin index / freq
HALF_SPECTRUM, 1, 1: only bins 0..NBINS/2-1 compete for peak; others accepted and discarded
SKIP_DC, 0, 1: bin 0 never competes for peak

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low
bin_valid  input  1  bin_d holds a valid bin
bin_ready  output  1  block can accept a bin this cycle
bin_d  input  2*DW  {real[2*DW-1:DW], imag[DW-1:0]}, two's complement
frame_start  input  1  qualified by bin_valid&bin_ready; marks the bin as index 0
done  output  1  one-cycle pulse: freq/peak_mag updated
freq  output  IDXW  index of peak bin of last completed frame
peak_mag  output  2*DW  magnitude of that bin, unsigned
busy  output  1  high while frame partially received or draining

Behaviour:
- Reset (rst=0, async): FSM=ACC, bin counter=0, running max=0, running index=0, pipeline valids=0; done=0, freq=0, peak_mag=0, busy=0, bin_ready=0 while rst low, 1 after release.
- Accept = bin_valid & bin_ready.
- Bin index = counter value at accept. Counter increments per accept and wraps to 0 after NBINS-1.
- frame_start on an accept:
  - forces that bin to index 0 and discards any partial frame (running max cleared, no done);
  - frame_start on a bin that is already index 0 has no extra effect.
- Magnitude = re*re + im*im, unsigned, 2*DW bits. -2^(DW-1) on both components yields 2^(2*DW-1), with no overflow.
- Pipeline:
  - S1 registers the squares, index and eligibility flag at the accept edge.
  - S2 adds the squares and compares against the running max at the next edge.
- Eligible bin = not (HALF_SPECTRUM and idx>=NBINS/2) and not (SKIP_DC and idx==0).
- Peak update only when eligible and mag strictly greater than the running max. Ties keep the lowest index.
- All-zero frame reports freq = first eligible index (0, or 1 with SKIP_DC) and peak_mag = 0, because the running max is initialised invalid and the first eligible bin always loads.
- FSM:
  - ACC: bin_ready=1. Accept of index NBINS-1 -> DRAIN1.
  - DRAIN1: bin_ready=0 -> DRAIN2.
  - DRAIN2: bin_ready=0; S2 result for the last bin is final. freq, peak_mag and done=1 are registered at the DRAIN2->ACC edge; the running max is cleared at the same edge.
- Latency: done is high in the 3rd cycle after the cycle in which the last bin was accepted.
- Throughput: NBINS+2 cycles per frame.
- freq/peak_mag hold until the next done. done is never high for two consecutive cycles.
- busy = (FSM != ACC) | (counter != 0).
- bin_valid while bin_ready=0: no accept; the source must hold the data (standard valid/ready).
- frame_start in DRAIN is ignored (no accept).
- Reset mid-frame or mid-drain: no done is issued. Outputs return to reset values immediately.

Optional Feature:
- Macro: FAS_MAG_APPROX_EN.
- Defined:
  - magnitude = |re| + |im| (DW+1 bits, zero-extended to 2*DW on peak_mag);
  - no multipliers; S1 registers absolute values.
  - |-2^(DW-1)| is computed in DW+1 bits, with no wrap.
  - Latency and FSM are unchanged.
- Undefined: squared magnitude as above.

Test Plan:
- NBINS=16, HALF_SPECTRUM=1, SKIP_DC=0. Frame with bin 3 = {16'd100,16'd0} and the rest zero, back-to-back valid -> done 3 cycles after the bin 15 accept; freq=3, peak_mag=10000; bin_ready low for exactly 2 cycles.
- Bins 2 and 5 both = {16'h8000,16'h8000} -> freq=2, peak_mag=32'h8000_0000 (tie keeps lowest, no overflow). Add bin 12 = {16'h7FFF,0} -> ignored (upper half), freq still 2.
- SKIP_DC=1, bin 0 = {1000,1000}, bin 1 = {1,0} -> freq=1, peak_mag=1; all-zero frame -> freq=1, peak_mag=0.
- Partial frame of 7 bins, then frame_start with a new full frame, peak at bin 4 = {0,-50} -> exactly one done; freq=4, peak_mag=2500. bin_valid toggling 50% duty -> same result.
- Assert rst low at DRAIN1 -> done never pulses; freq=0, peak_mag=0, busy=0. The next full frame reports normally.
- FAS_MAG_APPROX_EN defined, bin 6 = {-30,40}, bin 9 = {49,0} -> freq=6, peak_mag=70.
